// File: rtl/iir_fixed_pkg.sv
// Shared fixed-point definitions for the sign-magnitude IIR datapath (Q7.8 words).
package iir_fixed_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 8;
  localparam int MAG_W     = WIDTH - 1;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_word_t;

  localparam logic [MAG_W-1:0] SAT_MAG = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/sm_mag_saturate.sv
// Turns a raw unsigned magnitude product into a sign-magnitude word: rescale,
// saturate, and suppress negative zero.
module sm_mag_saturate #(
  parameter int MW        = 15,
  parameter int FRAC_BITS = 8
) (
  input  logic [2*MW-1:0] acc_i,
  input  logic            sign_i,
  output logic [MW:0]     word_o,
  output logic            overflow_o
);

  logic [2*MW-1:0] scaled;
  logic [MW-1:0]   mag;

  always_comb begin
    scaled     = acc_i >> FRAC_BITS;
    overflow_o = |scaled[2*MW-1:MW];
    mag        = overflow_o ? '1 : scaled[MW-1:0];
    word_o     = {sign_i & (|mag), mag};
  end

endmodule

// File: rtl/sm_mult_seq.sv
// Iterative shift-and-add sign-magnitude multiplier; one magnitude bit per clock,
// valid/ready handshake on operands and result.
module sm_mult_seq
  import iir_fixed_pkg::*;
#(
  parameter int WIDTH     = iir_fixed_pkg::WIDTH,
  parameter int FRAC_BITS = iir_fixed_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int MW    = WIDTH - 1;
  localparam int ACC_W = 2 * MW;
  localparam int CNT_W = $clog2(MW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MW - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [MW-1:0]      mag_a_q, mag_a_d;
  logic [MW-1:0]      mag_b_q, mag_b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_sum;
  logic [WIDTH-1:0]   sat_word;
  logic               sat_ovf;

  always_comb begin
    addend  = mag_b_q[cnt_q] ? (ACC_W'(mag_a_q) << cnt_q) : '0;
    acc_sum = acc_q + addend;
  end

  // Final partial product is folded in combinationally so the result registers
  // on the same edge as the last accumulate.
  sm_mag_saturate #(
    .MW        (MW),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .acc_i      (acc_sum),
    .sign_i     (sign_q),
    .word_o     (sat_word),
    .overflow_o (sat_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          sign_d  = operand_a[MW] ^ operand_b[MW];
          mag_a_d = operand_a[MW-1:0];
          mag_b_d = operand_b[MW-1:0];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = sat_word;
          ovf_d    = sat_ovf;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sm_mult_seq.sv
// Self-checking bench for sm_mult_seq: cycle-level transaction model plus directed literals.
module tb_sm_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sm_mult_seq #(
    .WIDTH     (16),
    .FRAC_BITS (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  // Reference product: {overflow, sign, magnitude} from plain integer arithmetic.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint ma, mb, p;
    logic [14:0] mag;
    logic ovf, sgn;
    ma = longint'(a[14:0]);
    mb = longint'(b[14:0]);
    p  = (ma * mb) / 256;
    if (p > 32767) begin
      mag = 15'h7FFF;
      ovf = 1'b1;
    end else begin
      mag = p[14:0];
      ovf = 1'b0;
    end
    sgn = (mag != 0) ? (a[15] ^ b[15]) : 1'b0;
    return {ovf, sgn, mag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op is outstanding from acceptance until the
  // result handshake; the result appears 15 edges after acceptance.
  logic        m_busy, m_outv, m_ovf, m_povf;
  logic [15:0] m_res, m_pres;
  int          m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_outv = 1'b0; m_res = '0; m_ovf = 1'b0;
      m_pres = '0; m_povf = 1'b0; m_edges = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  = 1'b1;
        m_edges = 0;
        {m_povf, m_pres} = ref_mul(operand_a, operand_b);
      end
    end else if (!m_outv) begin
      m_edges++;
      if (m_edges == 15) begin
        m_outv = 1'b1;
        m_res  = m_pres;
        m_ovf  = m_povf;
      end
    end else if (out_ready) begin
      m_outv = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_outv));
      chk("cyc_result", 32'(result), 32'(m_res));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b, input int hold,
                    output logic [15:0] r, output logic o);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; operand_a = a; operand_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd15);
    r = result;
    o = overflow;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] dir_a  [8] = '{16'h0180, 16'h8180, 16'h8180, 16'h7F00, 16'hFFFF, 16'h8000, 16'h8001, 16'h0180};
  logic [15:0] dir_b  [8] = '{16'h0200, 16'h0200, 16'h8200, 16'h0200, 16'h7FFF, 16'h0180, 16'h0001, 16'h0200};
  logic [15:0] dir_r  [8] = '{16'h0300, 16'h8300, 16'h0300, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0300};
  logic        dir_o  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int          dir_h  [8] = '{0, 1, 0, 2, 0, 1, 0, 5};

  initial begin
    logic [15:0] r, a, b;
    logic        o;
    logic [16:0] e;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      op(dir_a[i], dir_b[i], dir_h[i], r, o);
      chk("dir_result", 32'(r), 32'(dir_r[i]));
      chk("dir_overflow", 32'(o), 32'(dir_o[i]));
    end

    // Abort an operation partway through BUSY.
    @(posedge clk); #1;
    in_valid = 1'b1; operand_a = 16'h7FFF; operand_b = 16'h7FFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    op(16'h0100, 16'h0100, 0, r, o);
    chk("post_rst_result", 32'(r), 32'h0100);
    chk("post_rst_overflow", 32'(o), 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = 16'($urandom); b = 16'($urandom); end
        1: begin a = {1'($urandom), 15'($urandom_range(0, 16'h3FF))};
                 b = {1'($urandom), 15'($urandom_range(0, 16'h3FF))}; end
        2: begin a = {1'($urandom), 15'h0}; b = 16'($urandom); end
        default: begin a = {1'($urandom), 15'($urandom_range(16'h4000, 16'h7FFF))};
                       b = {1'($urandom), 15'($urandom_range(0, 16'h00FF))}; end
      endcase
      op(a, b, int'($urandom_range(0, 3)), r, o);
      e = ref_mul(a, b);
      chk("rnd_result", 32'(r), 32'(e[15:0]));
      chk("rnd_overflow", 32'(o), 32'(e[16]));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
